// File: rtl/cache_main_memory.sv
// Fixed-latency word-addressed backing store behind the write-back data cache.
// A single transaction is in flight at a time; mem_ready pulses LATENCY cycles after acceptance.
module cache_main_memory #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 20,
  parameter int LATENCY   = 4,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_ready,
  output logic              mem_busy
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] dout_q;
  logic              ready_q;
  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  // The array starts at zero and never sees rst.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  // Writes commit on the edge leaving DONE, ahead of any following acceptance.
  always_ff @(posedge clk) begin
    if (!rst && state_q == DONE && rw_q) mem_q[addr_q] <= data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            rw_q   <= mem_rw;
            addr_q <= mem_addr;
            data_q <= mem_data_in;
            cnt_q  <= 4'(LATENCY - 1);
            if (LATENCY > 1) begin
              state_q <= WAIT;
            end else begin
              state_q <= DONE;
              ready_q <= 1'b1;
              if (!mem_rw) dout_q <= mem_q[mem_addr];
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          // Read data lands on the edge entering DONE so it is valid with mem_ready.
          if (cnt_q == 4'd1) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            if (!rw_q) dout_q <= mem_q[addr_q];
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_data_out = dout_q;
  assign mem_ready    = ready_q;
  assign mem_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_cache_main_memory.sv
// Scoreboard bench for cache_main_memory: a LATENCY=4 instance driven by directed and
// random transactions, plus a LATENCY=1 instance exercised with a held request.
module tb_cache_main_memory;
  localparam int AW  = 10;
  localparam int DW  = 20;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req, rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, dout;
  logic          rdy, busy;

  logic          rst1, req1, rw1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] din1, dout1;
  logic          rdy1, busy1;

  cache_main_memory #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .INIT_FILE("")) u_dut (
    .clk(clk), .rst(rst), .mem_req(req), .mem_rw(rw), .mem_addr(addr),
    .mem_data_in(din), .mem_data_out(dout), .mem_ready(rdy), .mem_busy(busy));

  cache_main_memory #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .rst(rst1), .mem_req(req1), .mem_rw(rw1), .mem_addr(addr1),
    .mem_data_in(din1), .mem_data_out(dout1), .mem_ready(rdy1), .mem_busy(busy1));

  typedef struct {
    bit            rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            due;
  } txn_t;

  txn_t          sb_q[$];
  logic [DW-1:0] mdl [0:(1<<AW)-1];
  logic [DW-1:0] last_rd;
  int            vec = 0, errs = 0;
  int            cyc = 0, prev_rdy = -100, last_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pops one expectation per mem_ready pulse; a pulse with nothing pending is an error.
  always @(negedge clk) begin
    if (rdy) begin
      txn_t t;
      last_gap = cyc - prev_rdy;
      prev_rdy = cyc;
      if (sb_q.size() == 0) begin
        chk("spurious_ready", 32'd1, 32'd0);
      end else begin
        t = sb_q.pop_front();
        chk("ready_cycle", cyc, t.due);
        if (t.rd) begin
          chk("rd_data", {12'd0, dout}, {12'd0, t.d});
          last_rd = t.d;
        end else begin
          chk("wr_dout_hold", {12'd0, dout}, {12'd0, last_rd});
          mdl[t.a] = t.d;
        end
      end
    end
  end

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) chk("issue_timeout", 32'd1, 32'd0);
    rw = w; addr = a; din = d; req = 1'b1;
    sb_q.push_back('{rd: !w, a: a, d: (w ? d : mdl[a]), due: cyc + LAT});
    @(negedge clk);
    req = 1'b0; rw = 1'b0; addr = AW'($urandom); din = DW'($urandom);
    chk("busy_set", {31'd0, busy}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 32'd0);
    @(negedge clk);
    chk("idle_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mdl[i] = '0;
    last_rd = '0;
    rst = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; din = '0;
    rst1 = 1'b1; req1 = 1'b0; rw1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, rdy}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_dout",  {12'd0, dout}, 32'd0);
    rst = 1'b0;

    // Zero-initialised read, then write/read of the same word.
    issue(1'b0, 10'h000, '0);
    drain();
    issue(1'b1, 10'h2F7, 20'h3A5C1);
    issue(1'b0, 10'h2F7, '0);
    drain();
    chk("raw_2f7", {12'd0, dout}, 32'h3A5C1);

    // Request pulsed during WAIT must be ignored.
    issue(1'b1, 10'h010, 20'h0BEEF);
    issue(1'b0, 10'h010, '0);
    rw = 1'b1; addr = 10'h010; din = 20'hABCDE; req = 1'b1;
    @(negedge clk);
    req = 1'b0; rw = 1'b0;
    drain();
    issue(1'b0, 10'h010, '0);
    drain();
    chk("mask_010", {12'd0, dout}, 32'h0BEEF);

    // Writeback followed immediately by a line fill.
    issue(1'b1, 10'h1A3, 20'h54321);
    drain();
    issue(1'b1, 10'h123, 20'hFFFFF);
    issue(1'b0, 10'h1A3, '0);
    drain();
    chk("wbfill_gap", last_gap, LAT + 1);

    // Reset during a pending write discards it.
    issue(1'b1, 10'h055, 20'h0AAAA);
    drain();
    issue(1'b1, 10'h055, 20'h12345);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy",  {31'd0, busy}, 32'd0);
    chk("rstmid_ready", {31'd0, rdy}, 32'd0);
    chk("rstmid_dout",  {12'd0, dout}, 32'd0);
    last_rd = '0;
    repeat (6) @(negedge clk);
    rst = 1'b1; req = 1'b1; rw = 1'b0; addr = 10'h055;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    chk("rst_wins_busy", {31'd0, busy}, 32'd0);
    issue(1'b0, 10'h055, '0);
    drain();
    chk("rstmid_old", {12'd0, dout}, 32'h0AAAA);

    // Random mix over a small address set.
    for (int i = 0; i < 24; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), a, DW'($urandom));
    end
    drain();

    // LATENCY=1 instance: held read request yields a pulse every 2 cycles.
    rst1 = 1'b0;
    @(negedge clk);
    rw1 = 1'b1; addr1 = 10'h003; din1 = 20'h5A5A5; req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    chk("l1_wr_ready", {31'd0, rdy1}, 32'd1);
    @(negedge clk);
    rw1 = 1'b0; req1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("l1_ready", {31'd0, rdy1}, {31'd0, 1'(k % 2)});
      chk("l1_busy",  {31'd0, busy1}, {31'd0, 1'(k % 2)});
      if (k % 2 == 1) chk("l1_data", {12'd0, dout1}, 32'h5A5A5);
    end
    req1 = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
